// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Brief    : Registered NCH-channel, W-bit mux with manual select and a
//            dwell-timed round-robin scan, plus channel-change/wrap strobes.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int DWELL = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  din,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              hold,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   ch,
    output logic              chg,
    output logic              wrap
);

    localparam int                  c_CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [SELW-1:0]     c_CH_LAST  = SELW'(NCH - 1);

    logic [SELW-1:0]    r_ch;
    logic [c_CNT_W-1:0] r_cnt;
    logic [W-1:0]       r_dout;
    logic               r_chg;
    logic               r_wrap;

    logic [W-1:0]       w_chan [NCH];
    logic [SELW-1:0]    w_ch_nxt;
    logic               w_cnt_last;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_chan
            assign w_chan[k] = din[k*W +: W];
        end
    endgenerate

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_ch_nxt = r_ch;
        if (rst) begin
            w_ch_nxt = '0;
        end else if (hold) begin
            w_ch_nxt = r_ch;
        end else if (!mode) begin
            w_ch_nxt = sel;
        end else if (w_cnt_last) begin
            w_ch_nxt = r_ch + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_chg  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_ch   <= w_ch_nxt;
            // Sampled at the next channel so dout always matches ch.
            r_dout <= w_chan[w_ch_nxt];
            if (!mode) begin
                r_cnt <= '0;
            end else if (!hold) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
            end
            r_chg  <= (w_ch_nxt != r_ch);
            r_wrap <= mode && !hold && w_cnt_last && (r_ch == c_CH_LAST);
        end
    end

    assign dout = r_dout;
    assign ch   = r_ch;
    assign chg  = r_chg;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan
// Brief    : Self-checking bench for mux_scan against a countdown-style model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, hold;
    logic [15:0] din_a;
    logic [1:0]  sel_a;
    logic [3:0]  dout_a;
    logic [1:0]  ch_a;
    logic        chg_a, wrap_a;
    logic [7:0]  din_b;
    logic [2:0]  sel_b;
    logic [0:0]  dout_b;
    logic [2:0]  ch_b;
    logic        chg_b, wrap_b;

    mux_scan #(.NCH(4), .W(4), .DWELL(3)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .mode(mode), .hold(hold),
        .dout(dout_a), .ch(ch_a), .chg(chg_a), .wrap(wrap_a)
    );

    mux_scan #(.NCH(8), .W(1), .DWELL(1)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode), .hold(hold),
        .dout(dout_b), .ch(ch_b), .chg(chg_b), .wrap(wrap_b)
    );

    int checks = 0;
    int errors = 0;

    // Model state: channel and edges remaining before the next scan step.
    int  ma_ch = 0, ma_left = 3;
    int  mb_ch = 0, mb_left = 1;
    bit  ea_chg, ea_wrap, eb_chg, eb_wrap;
    int  ea_dout, eb_dout;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input int nch, input int dwell, input int s,
                         inout int mch, inout int left, output bit e_chg, output bit e_wrap);
        int nxt;
        e_chg  = 1'b0;
        e_wrap = 1'b0;
        if (rst) begin
            mch  = 0;
            left = dwell;
            return;
        end
        nxt = mch;
        if (!mode) begin
            if (!hold) nxt = s;
            left = dwell;
        end else if (!hold) begin
            left = left - 1;
            if (left == 0) begin
                left   = dwell;
                e_wrap = (mch == nch - 1);
                nxt    = (mch + 1) % nch;
            end
        end
        e_chg = (nxt != mch);
        mch   = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model(4, 3, int'(sel_a), ma_ch, ma_left, ea_chg, ea_wrap);
        model(8, 1, int'(sel_b), mb_ch, mb_left, eb_chg, eb_wrap);
        ea_dout = rst ? 0 : int'((din_a >> (ma_ch * 4)) & 16'hF);
        eb_dout = rst ? 0 : int'((din_b >> mb_ch) & 8'h1);
        #1;
        check_value("a_ch",   32'(ch_a),   32'(ma_ch));
        check_value("a_dout", 32'(dout_a), 32'(ea_dout));
        check_value("a_chg",  32'(chg_a),  32'(ea_chg));
        check_value("a_wrap", 32'(wrap_a), 32'(ea_wrap));
        check_value("b_ch",   32'(ch_b),   32'(mb_ch));
        check_value("b_dout", 32'(dout_b), 32'(eb_dout));
        check_value("b_chg",  32'(chg_b),  32'(eb_chg));
        check_value("b_wrap", 32'(wrap_b), 32'(eb_wrap));
    endtask

    int seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    initial begin
        rst = 1'b1; mode = 1'b0; hold = 1'b0;
        din_a = 16'hDCBA; sel_a = 2'd2;
        din_b = 8'h5A;    sel_b = 3'd5;
        step();
        step();
        check_value("rst_ch",   32'(ch_a),   32'd0);
        check_value("rst_dout", 32'(dout_a), 32'd0);

        rst = 1'b0;
        step();
        check_value("sel_ch",   32'(ch_a),   32'd2);
        check_value("sel_dout", 32'(dout_a), 32'hC);
        check_value("sel_chg",  32'(chg_a),  32'd1);
        step();
        check_value("sel_chg_pulse", 32'(chg_a), 32'd0);

        // Scan from channel 0 with a full dwell.
        sel_a = 2'd0; sel_b = 3'd0;
        step();
        mode = 1'b1;
        check_value("scan_seq0", 32'(ch_a), 32'(seq[0]));
        for (int i = 1; i < 13; i++) begin
            step();
            check_value("scan_seq", 32'(ch_a), 32'(seq[i]));
        end

        // Randomised phase: data, select, hold, mode flips and occasional reset.
        for (int i = 0; i < 400; i++) begin
            din_a = 16'($urandom);
            din_b = 8'($urandom);
            sel_a = 2'($urandom);
            sel_b = 3'($urandom);
            hold  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            rst   = ($urandom_range(0, 39) == 0);
            step();
        end

        // Long unheld scan: DWELL=1 block must step every edge.
        rst = 1'b0; hold = 1'b0; mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din_a = 16'($urandom);
            din_b = 8'($urandom);
            step();
            check_value("b_chg_cont", 32'(chg_b), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
